spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have parameter TX_WAIT_MAX, default 15, giving the maximum number of cycles READ_DATA waits for tx_valid after its rx_valid pulse.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port SS_n, input, 1 bit: active-low frame select.
REQ-005 The block SHALL have port MOSI, input, 1 bit: serial data in, MSB first, one bit per clk.
REQ-006 The block SHALL have port MISO, output, 1 bit: serial read data out, MSB first.
REQ-007 The block SHALL have port rx_data, output, 10 bits: received word; [9:8] is the command, [7:0] is the address or data.
REQ-008 The block SHALL have port rx_valid, output, 1 bit: one-cycle strobe qualifying rx_data toward the downstream RAM.
REQ-009 The block SHALL have port tx_data, input, 8 bits: RAM read data.
REQ-010 The block SHALL have port tx_valid, input, 1 bit: qualifies tx_data.

Function
REQ-011 FSM states SHALL be IDLE, CHK_CMD, WRITE, READ_ADD and READ_DATA.
REQ-012 IDLE SHALL go to CHK_CMD at the edge where SS_n is sampled low.
REQ-013 CHK_CMD SHALL capture MOSI as word bit 9 and set bit count to 1, then go to: WRITE if MOSI=0; READ_ADD if MOSI=1 and addr_rcvd=0; READ_DATA if MOSI=1 and addr_rcvd=1.
REQ-014 In WRITE, READ_ADD and READ_DATA, each edge SHALL shift MOSI in and increment the count; the edge that captures bit 0 (10th bit) SHALL load rx_data and assert rx_valid for exactly the following cycle.
REQ-015 Bits after the 10th SHALL be ignored in WRITE and READ_ADD, and SHALL never produce a second rx_valid within one frame.
REQ-016 addr_rcvd SHALL be set on the READ_ADD rx_valid and cleared on the READ_DATA rx_valid.
REQ-017 After its rx_valid, READ_DATA SHALL wait for tx_valid; on tx_valid it SHALL latch tx_data and drive bits 7..0 on MISO in the 8 following cycles, one bit per cycle.
REQ-018 If tx_valid does not arrive within TX_WAIT_MAX cycles, READ_DATA SHALL abandon the shift-out and MISO SHALL remain 0.
REQ-019 MISO SHALL be 0 whenever no shift-out is in progress.
REQ-020 SS_n sampled high in any non-IDLE state SHALL force IDLE on that edge: a partial word gives no rx_valid, any shift-out is aborted, MISO goes to 0 and addr_rcvd is unchanged.
REQ-021 If SS_n rises on the same edge that captures the 10th bit, the word SHALL complete and rx_valid SHALL still pulse.

Reset
REQ-022 With rst_n low, state SHALL be IDLE and rx_data=0, rx_valid=0, MISO=0, addr_rcvd=0, with all counters and shift registers cleared, asynchronously.
REQ-023 Reset asserted mid-frame SHALL discard the frame, and after release the block SHALL wait for SS_n low in IDLE.

Configuration
REQ-024 With macro SPI_SLAVE_CMD_CHECK_EN defined, a 1-bit output rx_err SHALL exist.
REQ-025 With SPI_SLAVE_CMD_CHECK_EN defined, a completed word whose [9:8] mismatches its state (READ_ADD requires 10, READ_DATA requires 11) SHALL produce no rx_valid, pulse rx_err for one cycle and leave addr_rcvd unchanged.
REQ-026 Without SPI_SLAVE_CMD_CHECK_EN, the rx_err port SHALL not exist and every completed word SHALL be forwarded unchanged.

Structure
REQ-027 Package spi_slave_pkg SHALL hold the state enum, FRAME_W=10, DATA_W=8 and command constants CMD_WR_ADDR=00, CMD_WR_DATA=01, CMD_RD_ADDR=10 and CMD_RD_DATA=11.
REQ-028 The MISO load/shift/count logic SHALL be one sub-module, spi_miso_shifter.

Verification
REQ-029 Write: the bench shall send frame 00_0000_0101 then frame 01_1010_1010 -> two rx_valid pulses with rx_data 0x005 and 0x1AA, and MISO stays 0.
REQ-030 Read: the bench shall send 10_0000_0101, then 11_xxxx_xxxx, then respond with tx_valid and tx_data=0xA5 -> rx_data 0x205 then 0x3xx, and MISO shows 1,0,1,0,0,1,0,1 on consecutive cycles.
REQ-031 Abort: the bench shall raise SS_n after 6 bits -> no rx_valid, state IDLE next cycle, and addr_rcvd unchanged.
REQ-032 Read with no prior address: the bench shall send MOSI=1 first with addr_rcvd=0 -> READ_ADD is entered, and with the macro, a word of 11_... gives rx_err=1 and no rx_valid.
REQ-033 Timeout: the bench shall send a READ_DATA word with no tx_valid for 20 cycles -> MISO stays 0, and a late tx_valid is ignored.
REQ-034 Reset: the bench shall assert rst_n during MISO shift-out -> MISO=0 and rx_valid=0 immediately, and the next frame decodes normally.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave: frame geometry, command codes,
// FSM state encoding and the command/state consistency check.
package spi_slave_pkg;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_e;

    // True when a completed word's command field is legal for the state that received it.
    function automatic logic cmd_matches(input state_e st, input logic [1:0] cmd);
        case (st)
            WRITE:     return (cmd == CMD_WR_ADDR) || (cmd == CMD_WR_DATA);
            READ_ADD:  return cmd == CMD_RD_ADDR;
            READ_DATA: return cmd == CMD_RD_DATA;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/spi_miso_shifter.sv
// MISO shift-out: loads one read byte and presents it MSB first, one bit per clk.
// An abort clears it at once; MISO is 0 whenever no byte is being shifted.
module spi_miso_shifter
    import spi_slave_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              abort,
    input  logic [DATA_W-1:0] load_data,
    output logic              miso
);

    localparam int SH_CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]   sr_q, sr_d;
    logic [SH_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (abort) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (load) begin
            sr_d  = load_data;
            cnt_d = SH_CNT_W'(DATA_W);
        end else if (cnt_q != '0) begin
            sr_d  = {sr_q[DATA_W-2:0], 1'b0};
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign miso = (cnt_q != '0) & sr_q[DATA_W-1];

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end for a small RAM: deserialises 10-bit command words and
// serves read data on MISO. Define SPI_SLAVE_CMD_CHECK_EN to add rx_err command checking.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int TX_WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
`ifdef SPI_SLAVE_CMD_CHECK_EN
    ,
    output logic               rx_err
`endif
);

    localparam int WAIT_W = (TX_WAIT_MAX > 1) ? $clog2(TX_WAIT_MAX) : 1;

    state_e             state_q, state_d;
    logic [FRAME_W-2:0] shift_q, shift_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               addr_rcvd_q, addr_rcvd_d;
    logic               wait_q, wait_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [FRAME_W-1:0] word;
    logic               word_done, word_ok;
    logic               sh_load, sh_abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!SS_n) state_d = CHK_CMD;
            CHK_CMD: begin
                if (SS_n)             state_d = IDLE;
                else if (!MOSI)       state_d = WRITE;
                else if (addr_rcvd_q) state_d = READ_DATA;
                else                  state_d = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: if (SS_n) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The final bit is taken straight from MOSI so the word can complete on the edge SS_n rises.
    assign word      = {shift_q, MOSI};
    assign word_done = (state_q == WRITE || state_q == READ_ADD || state_q == READ_DATA)
                       && (bit_cnt_q == CNT_W'(FRAME_W - 1));
`ifdef SPI_SLAVE_CMD_CHECK_EN
    assign word_ok   = cmd_matches(state_q, word[FRAME_W-1:FRAME_W-2]);
`else
    assign word_ok   = 1'b1;
`endif

    // NOTE: every signal assigned below gets a default first, so no latch can be inferred.
    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        addr_rcvd_d = addr_rcvd_q;
        wait_d      = wait_q;
        wait_cnt_d  = wait_cnt_q;
        sh_load     = 1'b0;
        sh_abort    = 1'b0;
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                wait_d    = 1'b0;
            end
            CHK_CMD: if (!SS_n) begin
                shift_d   = {{(FRAME_W-2){1'b0}}, MOSI};
                bit_cnt_d = CNT_W'(1);
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (bit_cnt_q < CNT_W'(FRAME_W)) begin
                    shift_d   = word[FRAME_W-2:0];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                if (word_done && word_ok) begin
                    rx_data_d  = word;
                    rx_valid_d = 1'b1;
                    if (state_q == READ_ADD) addr_rcvd_d = 1'b1;
                    if (state_q == READ_DATA) begin
                        addr_rcvd_d = 1'b0;
                        wait_d      = 1'b1;
                        wait_cnt_d  = '0;
                    end
                end
                if (wait_q) begin
                    if (tx_valid) begin
                        sh_load = 1'b1;
                        wait_d  = 1'b0;
                    end else if (wait_cnt_q == WAIT_W'(TX_WAIT_MAX - 1)) begin
                        wait_d = 1'b0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
                // Frame end wins over everything except a word completing on this edge.
                if (SS_n) begin
                    wait_d   = 1'b0;
                    sh_abort = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            addr_rcvd_q <= 1'b0;
            wait_q      <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            addr_rcvd_q <= addr_rcvd_d;
            wait_q      <= wait_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

`ifdef SPI_SLAVE_CMD_CHECK_EN
    logic rx_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_err_q <= 1'b0;
        else        rx_err_q <= word_done & ~word_ok;
    end

    assign rx_err = rx_err_q;
`endif

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

    spi_miso_shifter u_miso_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (sh_load),
        .abort     (sh_abort),
        .load_data (tx_data),
        .miso      (MISO)
    );

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: directed frames push expected words and MISO bits,
// an independent monitor compares them against rx_valid/rx_data/MISO every cycle.
module tb_spi_slave;
    import spi_slave_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
`ifdef SPI_SLAVE_CMD_CHECK_EN
    logic       rx_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] rx_q[$];
    logic       miso_q[$];
    logic       err_q[$];

    always #5 clk = ~clk;

    spi_slave #(.TX_WAIT_MAX(15)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
`ifdef SPI_SLAVE_CMD_CHECK_EN
        ,
        .rx_err   (rx_err)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic frame_begin();
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = 1'b0;
    endtask

    // Drive w[from_bit] down to w[to_bit]; optionally release SS_n together with the last bit.
    task automatic send_bits(input logic [9:0] w, input int from_bit, input int to_bit,
                             input bit release_last);
        for (int i = from_bit; i >= to_bit; i--) begin
            @(negedge clk);
            MOSI = w[i];
            if (release_last && i == to_bit) SS_n = 1'b1;
        end
    endtask

    task automatic frame_end();
        @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
    endtask

    task automatic send_word(input logic [9:0] w);
        frame_begin();
        send_bits(w, 9, 0, 1'b0);
        frame_end();
    endtask

    task automatic serve_read(input logic [7:0] d);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        for (int i = 7; i >= 0; i--) miso_q.push_back(d[i]);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rx_valid) begin
                if (rx_q.size() == 0) check("rx_valid_unexpected", 32'(rx_valid), 32'd0);
                else                  check("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
            end
            if (miso_q.size() != 0) check("miso_bit", 32'(MISO), 32'(miso_q.pop_front()));
            else                    check("miso_idle", 32'(MISO), 32'd0);
`ifdef SPI_SLAVE_CMD_CHECK_EN
            if (rx_err) begin
                check("rx_err_expected", 32'(err_q.size()), 32'd1);
                if (err_q.size() != 0) void'(err_q.pop_front());
            end
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        repeat (2) @(negedge clk);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_miso", 32'(MISO), 32'd0);
        check("reset_state", 32'(dut.state_q), 32'(IDLE));
        rst_n = 1'b1;

        // Writes; the first is followed by extra bits, the second releases SS_n with bit 0.
        rx_q.push_back(10'h005);
        frame_begin();
        send_bits(10'h005, 9, 0, 1'b0);
        send_bits(10'h3FF, 9, 7, 1'b0);
        frame_end();
        rx_q.push_back(10'h1AA);
        frame_begin();
        send_bits(10'h1AA, 9, 0, 1'b1);

        // Read: address then data, RAM answers 0xA5.
        rx_q.push_back(10'h205);
        send_word(10'h205);
        rx_q.push_back(10'h3C3);
        frame_begin();
        send_bits(10'h3C3, 9, 0, 1'b0);
        serve_read(8'hA5);
        repeat (9) @(negedge clk);
        frame_end();

        // Abort after 6 bits of a read-data word with an address pending.
        rx_q.push_back(10'h2F0);
        send_word(10'h2F0);
        frame_begin();
        send_bits(10'h3C3, 9, 4, 1'b0);
        @(negedge clk);
        SS_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_state", 32'(dut.state_q), 32'(IDLE));
        check("abort_addr_rcvd", 32'(dut.addr_rcvd_q), 32'd1);

        // Timeout: no tx_valid for 20 cycles, then a late one.
        rx_q.push_back(10'h3FF);
        frame_begin();
        send_bits(10'h3FF, 9, 0, 1'b0);
        repeat (20) @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (10) @(negedge clk);
        frame_end();
        check("timeout_addr_cleared", 32'(dut.addr_rcvd_q), 32'd0);

        // Read command with no address pending lands in READ_ADD.
        frame_begin();
        send_bits(10'h355, 9, 9, 1'b0);
        @(posedge clk);
        #1;
        check("noaddr_state", 32'(dut.state_q), 32'(READ_ADD));
`ifdef SPI_SLAVE_CMD_CHECK_EN
        err_q.push_back(1'b1);
`else
        rx_q.push_back(10'h355);
`endif
        send_bits(10'h355, 8, 0, 1'b0);
        frame_end();
`ifdef SPI_SLAVE_CMD_CHECK_EN
        check("noaddr_addr_rcvd", 32'(dut.addr_rcvd_q), 32'd0);
        rx_q.push_back(10'h2AB);
        send_word(10'h2AB);
`else
        check("noaddr_addr_rcvd", 32'(dut.addr_rcvd_q), 32'd1);
`endif

        // Reset during shift-out, three bits in.
        rx_q.push_back(10'h3C3);
        frame_begin();
        send_bits(10'h3C3, 9, 0, 1'b0);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        miso_q.push_back(1'b1);
        miso_q.push_back(1'b0);
        miso_q.push_back(1'b1);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        SS_n  = 1'b1;
        #1;
        check("midreset_miso", 32'(MISO), 32'd0);
        check("midreset_rx_valid", 32'(rx_valid), 32'd0);
        check("midreset_state", 32'(dut.state_q), 32'(IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        rx_q.push_back(10'h0C3);
        send_word(10'h0C3);
        rx_q.push_back(10'h2AB);
        send_word(10'h2AB);
        repeat (3) @(negedge clk);
        check("final_addr_rcvd", 32'(dut.addr_rcvd_q), 32'd1);

        check("rx_q_drained", 32'(rx_q.size()), 32'd0);
        check("miso_q_drained", 32'(miso_q.size()), 32'd0);
        check("err_q_drained", 32'(err_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
